mmio_perf_counters: RTL and testbench

Memory-mapped performance-counter read port in the EXM stage, directly downstream of `Inst_Counters`. It keeps a free-running cycle counter and a conditional-branch counter, and consumes the `insts` count produced by `Inst_Counters`. It decodes loads in EXM that target the counter window and returns the selected value, registered, to the writeback-stage load mux. A store to the counter-reset address clears its own counters on the same edge that `Inst_Counters` clears `insts`.

---
 rtl/mmio_perf_counters.sv | 100 ++++++++++
 tb/tb_mmio_perf_counters.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_perf_counters.sv
// Performance-counter load window in EXM: free-running cycle and branch counters plus
// an insts/branch snapshot pair, returned registered to the WB-stage load mux.
module mmio_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] EXMinst,
  input  logic [31:0] addr,
  input  logic [3:0]  wbe,
  input  logic [31:0] insts,
  output logic [31:0] mmio_rdata,
  output logic        mmio_hit
);

  localparam logic [31:0] ADDR_CYC  = 32'h8000_0010;
  localparam logic [31:0] ADDR_INST = 32'h8000_0014;
  localparam logic [31:0] ADDR_RST  = 32'h8000_0018;
  localparam logic [31:0] ADDR_BR   = 32'h8000_001C;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state, state_next;
  logic [31:0] cyc_cnt, br_cnt, snap_inst, snap_br;
  logic [31:0] rd_value;
  logic        ld, br, clr, capture, accept;
  logic        sel_cyc, sel_inst, sel_rst, sel_br, sel_any;

  // Word-granular decode: byte/halfword loads see the full word and WB masks it.
  assign sel_cyc  = (addr[31:2] == ADDR_CYC[31:2]);
  assign sel_inst = (addr[31:2] == ADDR_INST[31:2]);
  assign sel_rst  = (addr[31:2] == ADDR_RST[31:2]);
  assign sel_br   = (addr[31:2] == ADDR_BR[31:2]);
  assign sel_any  = sel_cyc | sel_inst | sel_rst | sel_br;

  assign ld     = (EXMinst[6:0] == OP_LOAD)   && !stall;
  assign br     = (EXMinst[6:0] == OP_BRANCH) && !stall;
  assign clr    = (wbe != 4'h0) && sel_rst && !stall;
  assign accept = ld && sel_any && !clr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (clr) begin
      state_next = IDLE;
    end else if (ld && sel_cyc) begin
      state_next = LOCKED;
      capture    = 1'b1;
    end else if (ld && sel_br && state == LOCKED) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    rd_value = '0;
    if (sel_cyc)       rd_value = cyc_cnt;
    else if (sel_inst) rd_value = (state == LOCKED) ? snap_inst : insts;
    else if (sel_br)   rd_value = (state == LOCKED) ? snap_br : br_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; snapshots and read data rely on seeing the old br_cnt/cyc_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt    <= '0;
      br_cnt     <= '0;
      snap_inst  <= '0;
      snap_br    <= '0;
      mmio_rdata <= '0;
      mmio_hit   <= 1'b0;
    end else begin
      cyc_cnt <= clr ? '0 : cyc_cnt + 32'd1;
      if (clr)     br_cnt <= '0;
      else if (br) br_cnt <= br_cnt + 32'd1;

      if (clr) begin
        snap_inst <= '0;
        snap_br   <= '0;
      end else if (capture) begin
        snap_inst <= insts;
        snap_br   <= br_cnt;
      end

      // A stalled EXM instruction is not retired, so the WB-facing outputs hold.
      if (!stall) begin
        mmio_hit <= accept;
        if (accept) mmio_rdata <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_mmio_perf_counters.sv
// Bench for mmio_perf_counters: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the counter window.
module tb_mmio_perf_counters;

  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INST = 32'h8000_0014;
  localparam logic [31:0] A_RST  = 32'h8000_0018;
  localparam logic [31:0] A_BR   = 32'h8000_001C;
  localparam logic [31:0] I_LD   = 32'h0100_2083;
  localparam logic [31:0] I_BR   = 32'hF420_9EE3;
  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_ST   = 32'h0020_2023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] EXMinst = I_NOP;
  logic [31:0] addr = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] insts = '0;
  logic [31:0] mmio_rdata;
  logic        mmio_hit;

  always #5 clk = ~clk;

  mmio_perf_counters dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .EXMinst    (EXMinst),
    .addr       (addr),
    .wbe        (wbe),
    .insts      (insts),
    .mmio_rdata (mmio_rdata),
    .mmio_hit   (mmio_hit)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: counters, snapshot lock flag, and expected WB outputs.
  logic [31:0] m_cyc, m_br, m_snap_inst, m_snap_br, m_rdata;
  logic        m_locked, m_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Applies one clock edge's worth of the window's rules to the model.
  task automatic model_edge();
    logic        is_ld, is_br, is_clr, in_win;
    logic [31:0] off, val;
    int          idx;
    if (!rst_n) begin
      m_cyc = '0; m_br = '0; m_snap_inst = '0; m_snap_br = '0;
      m_rdata = '0; m_hit = 1'b0; m_locked = 1'b0;
      return;
    end
    is_ld  = (EXMinst[6:0] == 7'h03) && !stall;
    is_br  = (EXMinst[6:0] == 7'h63) && !stall;
    off    = (addr & 32'hFFFF_FFFC) - A_CYC;
    in_win = (off < 32'd16);
    idx    = in_win ? int'(off >> 2) : -1;
    is_clr = (wbe != 4'h0) && (idx == 2) && !stall;
    case (idx)
      0:       val = m_cyc;
      1:       val = m_locked ? m_snap_inst : insts;
      3:       val = m_locked ? m_snap_br : m_br;
      default: val = '0;
    endcase
    if (!stall) begin
      m_hit = is_ld && in_win && !is_clr;
      if (m_hit) m_rdata = val;
    end
    if (is_clr) begin
      m_locked = 1'b0; m_snap_inst = '0; m_snap_br = '0;
    end else if (is_ld && idx == 0) begin
      m_locked = 1'b1; m_snap_inst = insts; m_snap_br = m_br;
    end else if (is_ld && idx == 3 && m_locked) begin
      m_locked = 1'b0;
    end
    m_cyc = is_clr ? 32'd0 : m_cyc + 32'd1;
    m_br  = is_clr ? 32'd0 : m_br + (is_br ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input logic s, input logic [31:0] i, input logic [31:0] a,
                       input logic [3:0] w);
    stall = s; EXMinst = i; addr = a; wbe = w;
  endtask

  // One clock: model the edge, let the DUT take it, compare at the falling edge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hit"}, {31'd0, mmio_hit}, {31'd0, m_hit});
    check({tag, "_rdata"}, mmio_rdata, m_rdata);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, I_NOP, 32'h0, 4'h0);
      cycle("nop");
    end
  endtask

  task automatic load(input string tag, input logic [31:0] a);
    drive(1'b0, I_LD, a, 4'h0);
    cycle(tag);
  endtask

  initial begin
    int          r;
    logic [31:0] rv;
    @(negedge clk);

    // 1. Reset and cycle count.
    rst_n = 1'b0;
    cycle("rst0");
    cycle("rst1");
    check("rst_hit_zero", {31'd0, mmio_hit}, 32'd0);
    check("rst_rdata_zero", mmio_rdata, 32'd0);
    rst_n = 1'b1;
    nops(5);
    load("tp1_ld1", A_CYC);
    check("tp1_cyc_is_5", mmio_rdata, 32'd5);
    check("tp1_hit", {31'd0, mmio_hit}, 32'd1);
    nops(3);
    load("tp1_ld2", A_CYC);
    check("tp1_cyc_is_9", mmio_rdata, 32'd9);

    // 2. Branch count (first leave LOCKED so BR reads live).
    load("tp2_unlock", A_BR);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, I_BR, 32'h0, 4'h0); cycle("tp2_br");
      nops(1);
    end
    load("tp2_ldbr", A_BR);
    check("tp2_br_is_3", mmio_rdata, 32'd3);
    drive(1'b0, I_ST, A_RST, 4'hF); cycle("tp2_clr");
    for (int k = 0; k < 3; k++) begin
      drive(k == 1, I_BR, 32'h0, 4'h0); cycle("tp2_br_st");
      nops(1);
    end
    load("tp2_ldbr2", A_BR);
    check("tp2_br_is_2", mmio_rdata, 32'd2);

    // 3. Snapshot.
    insts = 32'd7;
    load("tp3_ldcyc", A_CYC);
    insts = 32'd9;
    load("tp3_ldinst", A_INST);
    check("tp3_snap_inst_7", mmio_rdata, 32'd7);
    load("tp3_ldbr", A_BR);
    check("tp3_snap_br_2", mmio_rdata, 32'd2);
    load("tp3_ldinst_live", A_INST);
    check("tp3_live_inst_9", mmio_rdata, 32'd9);

    // 4. Counter reset from LOCKED.
    load("tp4_lock", A_CYC);
    nops(20);
    drive(1'b0, I_ST, A_RST, 4'hF); cycle("tp4_clr");
    check("tp4_clr_no_hit", {31'd0, mmio_hit}, 32'd0);
    load("tp4_ldcyc", A_CYC);
    check("tp4_cyc_is_0", mmio_rdata, 32'd0);
    load("tp4_ldbr", A_BR);
    check("tp4_br_is_0", mmio_rdata, 32'd0);
    insts = 32'h55;
    load("tp4_idle_inst", A_INST);
    check("tp4_idle_live_inst", mmio_rdata, 32'h55);
    drive(1'b0, I_BR, 32'h0, 4'h0); cycle("tp4_br");
    drive(1'b0, I_ST, A_RST, 4'h0); cycle("tp4_st_wbe0");
    load("tp4_ldbr2", A_BR);
    check("tp4_wbe0_keeps_br", mmio_rdata, 32'd1);

    // 5. Miss, hold and stalled load.
    load("tp5_miss", 32'h1000_0000);
    check("tp5_miss_hit", {31'd0, mmio_hit}, 32'd0);
    check("tp5_miss_hold", mmio_rdata, 32'd1);
    drive(1'b1, I_LD, A_CYC, 4'h0); cycle("tp5_stall0");
    check("tp5_stall0_hit", {31'd0, mmio_hit}, 32'd0);
    cycle("tp5_stall1");
    check("tp5_stall1_hit", {31'd0, mmio_hit}, 32'd0);
    drive(1'b0, I_LD, A_CYC, 4'h0); cycle("tp5_go");
    check("tp5_go_hit", {31'd0, mmio_hit}, 32'd1);

    // 6. Wrap.
    drive(1'b0, I_LD, A_CYC, 4'h0);
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    #1 release dut.cyc_cnt;
    m_cyc = 32'hFFFF_FFFE;
    cycle("tp6_w0");
    check("tp6_fffffffe", mmio_rdata, 32'hFFFF_FFFE);
    cycle("tp6_w1");
    check("tp6_ffffffff", mmio_rdata, 32'hFFFF_FFFF);
    cycle("tp6_w2");
    check("tp6_wrap_0", mmio_rdata, 32'h0000_0000);

    // Randomized traffic, including mid-run resets and decode faults.
    for (int n = 0; n < 600; n++) begin
      r     = int'($urandom_range(0, 99));
      rst_n = (r >= 2);
      stall = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0, 1:    EXMinst = I_LD;
        2:       EXMinst = I_BR;
        3:       EXMinst = I_ST;
        4:       EXMinst = I_NOP;
        default: EXMinst = $urandom;
      endcase
      rv   = $urandom;
      addr = ($urandom_range(0, 9) < 8) ? A_CYC + {28'd0, rv[3:0]} : rv;
      if (EXMinst == I_ST)                wbe = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 19) == 0) wbe = 4'($urandom_range(1, 15));
      else                                 wbe = 4'h0;
      if ($urandom_range(0, 3) == 0) insts = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
